// File: rtl/sf_snp_issuer.sv
// HN-F snoop initiator: fans one SF-hit request out as serialised snoops to the sharing RN-Fs,
// gathers their responses and returns a single merged completion.
module sf_snp_issuer #(
   parameter int unsigned NUM_RN  = 4,
   parameter int unsigned ADDR_W  = 48,
   parameter int unsigned TXNID_W = 12,
   localparam int unsigned IDX_W  = (NUM_RN > 1) ? $clog2(NUM_RN) : 1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [ADDR_W-1:0]  req_addr,
   input  logic               req_unique,
   input  logic [TXNID_W-1:0] req_txnid,
   input  logic [NUM_RN-1:0]  req_rnf_vec,
   input  logic [IDX_W-1:0]   req_src_idx,
   output logic               snp_valid,
   input  logic               snp_ready,
   output logic [IDX_W-1:0]   snp_tgt_idx,
   output logic [4:0]         snp_opcode,
   output logic [ADDR_W-1:0]  snp_addr,
   output logic [TXNID_W-1:0] snp_txnid,
   input  logic               rsp_valid,
   input  logic [IDX_W-1:0]   rsp_src_idx,
   input  logic               rsp_pass_dirty,
   input  logic               rsp_has_data,
   output logic               done_valid,
   input  logic               done_ready,
   output logic [TXNID_W-1:0] done_txnid,
   output logic               done_dirty,
   output logic               done_data,
   output logic [NUM_RN-1:0]  done_rnf_vec,
   output logic               err
);

   localparam int unsigned CNT_W = IDX_W + 1;
   localparam logic [4:0] SnpShared = 5'h01;
   localparam logic [4:0] SnpUnique = 5'h07;
   localparam logic [NUM_RN-1:0] OneLsb = {{(NUM_RN-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

   state_e               state_q;
   logic [ADDR_W-1:0]    addr_q;
   logic [TXNID_W-1:0]   txnid_q;
   logic [4:0]           opcode_q;
   logic [NUM_RN-1:0]    pending_q;
   logic [NUM_RN-1:0]    sent_q;
   logic [NUM_RN-1:0]    resp_q;
   logic [NUM_RN-1:0]    done_vec_q;
   logic [CNT_W-1:0]     outstanding_q;
   logic                 dirty_q;
   logic                 data_q;
   logic                 err_q;

   logic [IDX_W-1:0]     tgt_idx;
   logic [NUM_RN-1:0]    tgt_oh;
   logic [NUM_RN-1:0]    req_oh;
   logic [NUM_RN-1:0]    rsp_oh;
   logic [NUM_RN-1:0]    req_target;
   logic [NUM_RN-1:0]    pending_d;
   logic [CNT_W-1:0]     outstanding_d;
   logic                 snp_hs;
   logic                 rsp_counted;

   // Lowest-index pending RN-F is always the one offered on the snoop channel.
   always_comb begin
      tgt_idx = '0;
      for (int i = int'(NUM_RN) - 1; i >= 0; i--) begin
         if (pending_q[i]) tgt_idx = IDX_W'(i);
      end
   end

   always_comb begin
      tgt_oh        = OneLsb << tgt_idx;
      req_oh        = OneLsb << req_src_idx;
      rsp_oh        = OneLsb << rsp_src_idx;
      req_target    = req_rnf_vec & ~req_oh;
      snp_hs        = (state_q == StIssue) && snp_ready;
      rsp_counted   = rsp_valid && (32'(rsp_src_idx) < NUM_RN) &&
                      sent_q[rsp_src_idx] && !resp_q[rsp_src_idx];
      pending_d     = snp_hs ? (pending_q & ~tgt_oh) : pending_q;
      outstanding_d = outstanding_q + CNT_W'(snp_hs) - CNT_W'(rsp_counted);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= StIdle;
         addr_q        <= '0;
         txnid_q       <= '0;
         opcode_q      <= '0;
         pending_q     <= '0;
         sent_q        <= '0;
         resp_q        <= '0;
         done_vec_q    <= '0;
         outstanding_q <= '0;
         dirty_q       <= 1'b0;
         data_q        <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         // Anything not matching an unanswered sent snoop is dropped and flagged.
         if (rsp_valid && !rsp_counted) err_q <= 1'b1;
         if (rsp_counted) begin
            resp_q  <= resp_q | rsp_oh;
            dirty_q <= dirty_q | rsp_pass_dirty;
            data_q  <= data_q | rsp_has_data;
         end
         outstanding_q <= outstanding_d;

         unique case (state_q)
            StIdle: begin
               if (req_valid) begin
                  addr_q        <= req_addr;
                  txnid_q       <= req_txnid;
                  opcode_q      <= req_unique ? SnpUnique : SnpShared;
                  pending_q     <= req_target;
                  sent_q        <= '0;
                  resp_q        <= '0;
                  outstanding_q <= '0;
                  dirty_q       <= 1'b0;
                  data_q        <= 1'b0;
                  done_vec_q    <= req_unique ? req_oh : (req_rnf_vec | req_oh);
                  state_q       <= (req_target != '0) ? StIssue : StDone;
               end
            end
            StIssue: begin
               if (snp_hs) begin
                  pending_q <= pending_d;
                  sent_q    <= sent_q | tgt_oh;
               end
               if (pending_d == '0) begin
                  state_q <= (outstanding_d == '0) ? StDone : StWait;
               end
            end
            StWait: begin
               if (outstanding_d == '0) state_q <= StDone;
            end
            StDone: begin
               if (done_ready) begin
                  sent_q  <= '0;
                  resp_q  <= '0;
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign req_ready    = (state_q == StIdle);
   assign snp_valid    = (state_q == StIssue);
   assign snp_tgt_idx  = tgt_idx;
   assign snp_opcode   = opcode_q;
   assign snp_addr     = addr_q;
   assign snp_txnid    = txnid_q;
   assign done_valid   = (state_q == StDone);
   assign done_txnid   = txnid_q;
   assign done_dirty   = dirty_q;
   assign done_data    = data_q;
   assign done_rnf_vec = done_vec_q;
   assign err          = err_q;

endmodule

// File: tb/tb_sf_snp_issuer.sv
// Self-checking bench for sf_snp_issuer: table-driven transactions with a snoop/completion
// scoreboard, plus hand-written stall, error and reset sequences.
module tb_sf_snp_issuer;

   localparam int NUM_RN  = 4;
   localparam int ADDR_W  = 48;
   localparam int TXNID_W = 12;
   localparam int IDX_W   = 2;

   logic               clock = 1'b0;
   logic               reset = 1'b0;
   logic               req_valid = 1'b0;
   logic               req_ready;
   logic [ADDR_W-1:0]  req_addr = '0;
   logic               req_unique = 1'b0;
   logic [TXNID_W-1:0] req_txnid = '0;
   logic [NUM_RN-1:0]  req_rnf_vec = '0;
   logic [IDX_W-1:0]   req_src_idx = '0;
   logic               snp_valid;
   logic               snp_ready = 1'b0;
   logic [IDX_W-1:0]   snp_tgt_idx;
   logic [4:0]         snp_opcode;
   logic [ADDR_W-1:0]  snp_addr;
   logic [TXNID_W-1:0] snp_txnid;
   logic               rsp_valid = 1'b0;
   logic [IDX_W-1:0]   rsp_src_idx = '0;
   logic               rsp_pass_dirty = 1'b0;
   logic               rsp_has_data = 1'b0;
   logic               done_valid;
   logic               done_ready = 1'b0;
   logic [TXNID_W-1:0] done_txnid;
   logic               done_dirty;
   logic               done_data;
   logic [NUM_RN-1:0]  done_rnf_vec;
   logic               err;

   sf_snp_issuer #(.NUM_RN(NUM_RN), .ADDR_W(ADDR_W), .TXNID_W(TXNID_W)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_unique(req_unique), .req_txnid(req_txnid), .req_rnf_vec(req_rnf_vec),
      .req_src_idx(req_src_idx),
      .snp_valid(snp_valid), .snp_ready(snp_ready), .snp_tgt_idx(snp_tgt_idx),
      .snp_opcode(snp_opcode), .snp_addr(snp_addr), .snp_txnid(snp_txnid),
      .rsp_valid(rsp_valid), .rsp_src_idx(rsp_src_idx), .rsp_pass_dirty(rsp_pass_dirty),
      .rsp_has_data(rsp_has_data),
      .done_valid(done_valid), .done_ready(done_ready), .done_txnid(done_txnid),
      .done_dirty(done_dirty), .done_data(done_data), .done_rnf_vec(done_rnf_vec),
      .err(err)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [3:0] vec;
      logic [1:0] src;
      logic       uniq;
      logic [3:0] dirty_m;
      logic [3:0] data_m;
      logic       rdy_rand;
      logic [3:0] exp_vec;
      logic       exp_dirty;
      logic       exp_data;
   } vec_t;

   typedef struct {
      logic [1:0]         tgt;
      logic [4:0]         op;
      logic [ADDR_W-1:0]  addr;
      logic [TXNID_W-1:0] txn;
   } snp_exp_t;

   typedef struct {
      logic [TXNID_W-1:0] txn;
      logic               dirty;
      logic               data;
      logic [3:0]         vec;
   } done_exp_t;

   vec_t       tbl [7];
   snp_exp_t   snp_q [$];
   done_exp_t  done_q [$];
   logic [1:0] sent_log [$];
   bit         done_seen;
   int         nvec = 0;
   int         nfail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic monitor();
      snp_exp_t  s;
      done_exp_t d;
      if (snp_valid && snp_ready) begin
         if (snp_q.size() == 0) chk("snp_unexpected", 64'd1, 64'd0);
         else begin
            s = snp_q.pop_front();
            chk("snp_tgt", 64'(snp_tgt_idx), 64'(s.tgt));
            chk("snp_opcode", 64'(snp_opcode), 64'(s.op));
            chk("snp_addr", 64'(snp_addr), 64'(s.addr));
            chk("snp_txnid", 64'(snp_txnid), 64'(s.txn));
         end
         sent_log.push_back(snp_tgt_idx);
      end
      if (done_valid && done_ready) begin
         done_seen = 1'b1;
         if (done_q.size() == 0) chk("done_unexpected", 64'd1, 64'd0);
         else begin
            d = done_q.pop_front();
            chk("done_txnid", 64'(done_txnid), 64'(d.txn));
            chk("done_dirty", 64'(done_dirty), 64'(d.dirty));
            chk("done_data", 64'(done_data), 64'(d.data));
            chk("done_rnf_vec", 64'(done_rnf_vec), 64'(d.vec));
         end
      end
   endtask

   task automatic step();
      @(negedge clock);
      monitor();
      @(posedge clock);
      #1;
   endtask

   task automatic push_txn(input logic [3:0] vec, input logic [1:0] src, input logic uniq,
                           input logic [ADDR_W-1:0] addr, input logic [TXNID_W-1:0] txn,
                           input logic e_dirty, input logic e_data, input logic [3:0] e_vec);
      logic [3:0] target;
      target = vec & ~(4'b0001 << src);
      for (int i = 0; i < NUM_RN; i++) begin
         if (target[i]) snp_q.push_back('{2'(i), uniq ? 5'h07 : 5'h01, addr, txn});
      end
      done_q.push_back('{txn, e_dirty, e_data, e_vec});
   endtask

   task automatic accept(input logic [3:0] vec, input logic [1:0] src, input logic uniq,
                         input logic [ADDR_W-1:0] addr, input logic [TXNID_W-1:0] txn);
      chk("req_ready_idle", 64'(req_ready), 64'd1);
      req_valid   = 1'b1;
      req_rnf_vec = vec;
      req_src_idx = src;
      req_unique  = uniq;
      req_addr    = addr;
      req_txnid   = txn;
      step();
      // Scramble request fields so any failure to latch shows up on the outputs.
      req_valid   = 1'b0;
      req_rnf_vec = 4'($urandom);
      req_src_idx = 2'($urandom);
      req_unique  = 1'($urandom);
      req_addr    = {16'($urandom), 32'($urandom)};
      req_txnid   = 12'($urandom);
   endtask

   task automatic run_vec(input int i, input logic exp_err);
      vec_t              v;
      logic [3:0]        target;
      logic [ADDR_W-1:0] addr;
      logic [TXNID_W-1:0] txn;
      logic [1:0]        t;
      v      = tbl[i];
      target = v.vec & ~(4'b0001 << v.src);
      addr   = {16'($urandom), 32'($urandom)};
      txn    = 12'h100 + 12'(i);
      push_txn(v.vec, v.src, v.uniq, addr, txn, v.exp_dirty, v.exp_data, v.exp_vec);
      sent_log.delete();
      done_seen = 1'b0;
      accept(v.vec, v.src, v.uniq, addr, txn);
      chk($sformatf("first_latency[%0d]", i),
          64'((target != 4'b0000) ? snp_valid : done_valid), 64'd1);
      for (int c = 0; c < 200 && !done_seen; c++) begin
         snp_ready  = v.rdy_rand ? 1'($urandom) : 1'b1;
         done_ready = 1'($urandom) | (c > 20);
         if (sent_log.size() != 0 && $urandom_range(0, 2) != 0) begin
            t              = sent_log.pop_back();
            rsp_valid      = 1'b1;
            rsp_src_idx    = t;
            rsp_pass_dirty = v.dirty_m[t];
            rsp_has_data   = v.data_m[t];
         end else begin
            rsp_valid = 1'b0;
         end
         step();
      end
      rsp_valid  = 1'b0;
      snp_ready  = 1'b0;
      done_ready = 1'b0;
      if (!done_seen) chk($sformatf("done_timeout[%0d]", i), 64'd0, 64'd1);
      chk($sformatf("req_ready_after[%0d]", i), 64'(req_ready), 64'd1);
      chk($sformatf("snp_left[%0d]", i), 64'(snp_q.size()), 64'd0);
      chk($sformatf("err[%0d]", i), 64'(err), 64'(exp_err));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   initial begin
      logic [ADDR_W-1:0] a;
      //          vec      src   uniq  dirty    data     rrand exp_vec  dty   dat
      tbl[0] = '{4'b0000, 2'd0, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0001, 1'b0, 1'b0};
      tbl[1] = '{4'b1011, 2'd1, 1'b1, 4'b1000, 4'b0001, 1'b0, 4'b0010, 1'b1, 1'b1};
      tbl[2] = '{4'b0110, 2'd0, 1'b0, 4'b0000, 4'b0100, 1'b0, 4'b0111, 1'b0, 1'b1};
      tbl[3] = '{4'b1111, 2'd3, 1'b0, 4'b0010, 4'b0000, 1'b1, 4'b1111, 1'b1, 1'b0};
      tbl[4] = '{4'b1000, 2'd3, 1'b1, 4'b0000, 4'b0000, 1'b1, 4'b1000, 1'b0, 1'b0};
      tbl[5] = '{4'b1111, 2'd2, 1'b1, 4'b0100, 4'b1000, 1'b0, 4'b0100, 1'b0, 1'b1};
      tbl[6] = '{4'b0101, 2'd1, 1'b0, 4'b0001, 4'b0001, 1'b1, 4'b0111, 1'b1, 1'b1};

      // Reset values
      @(posedge clock);
      #1;
      chk("rst_req_ready", 64'(req_ready), 64'd1);
      chk("rst_snp_valid", 64'(snp_valid), 64'd0);
      chk("rst_snp_opcode", 64'(snp_opcode), 64'd0);
      chk("rst_done_valid", 64'(done_valid), 64'd0);
      chk("rst_done_rnf_vec", 64'(done_rnf_vec), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      reset = 1'b1;
      step();

      for (int i = 0; i < 7; i++) run_vec(i, 1'b0);

      // Snoop stall, then response to RN-F 1 in the same cycle the snoop to RN-F 2 issues
      a = 48'h0000_1234_5680;
      push_txn(4'b0110, 2'd0, 1'b0, a, 12'hABC, 1'b0, 1'b1, 4'b0111);
      accept(4'b0110, 2'd0, 1'b0, a, 12'hABC);
      snp_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("stall_valid", 64'(snp_valid), 64'd1);
         chk("stall_tgt", 64'(snp_tgt_idx), 64'd1);
         chk("stall_addr", 64'(snp_addr), 64'(a));
         step();
      end
      snp_ready = 1'b1;
      step();
      rsp_valid = 1'b1; rsp_src_idx = 2'd1; rsp_pass_dirty = 1'b0; rsp_has_data = 1'b0;
      step();
      snp_ready = 1'b0;
      rsp_valid = 1'b0;
      step();
      chk("wait_no_done0", 64'(done_valid), 64'd0);
      step();
      chk("wait_no_done1", 64'(done_valid), 64'd0);
      rsp_valid = 1'b1; rsp_src_idx = 2'd2; rsp_pass_dirty = 1'b0; rsp_has_data = 1'b1;
      done_ready = 1'b0;
      step();
      rsp_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         chk("hold_done_valid", 64'(done_valid), 64'd1);
         chk("hold_req_ready", 64'(req_ready), 64'd0);
         chk("hold_rnf_vec", 64'(done_rnf_vec), 64'b0111);
         chk("hold_data", 64'(done_data), 64'd1);
         step();
      end
      done_ready = 1'b1;
      done_seen  = 1'b0;
      step();
      done_ready = 1'b0;
      chk("hold_handshake", 64'(done_seen), 64'd1);
      chk("hold_req_ready_after", 64'(req_ready), 64'd1);
      chk("hold_err", 64'(err), 64'd0);

      // Duplicate response while DONE is ignored and flags err
      a = 48'h0000_0BAD_C0C0;
      push_txn(4'b0010, 2'd0, 1'b0, a, 12'h055, 1'b0, 1'b0, 4'b0011);
      accept(4'b0010, 2'd0, 1'b0, a, 12'h055);
      snp_ready = 1'b1;
      step();
      snp_ready = 1'b0;
      rsp_valid = 1'b1; rsp_src_idx = 2'd1; rsp_pass_dirty = 1'b0; rsp_has_data = 1'b0;
      step();
      chk("dup_pre_err", 64'(err), 64'd0);
      rsp_pass_dirty = 1'b1; rsp_has_data = 1'b1;
      step();
      rsp_valid = 1'b0;
      chk("dup_err", 64'(err), 64'd1);
      chk("dup_dirty", 64'(done_dirty), 64'd0);
      chk("dup_data", 64'(done_data), 64'd0);
      done_ready = 1'b1;
      step();
      done_ready = 1'b0;

      // Response while IDLE
      reset = 1'b0;
      #1;
      chk("rst2_err", 64'(err), 64'd0);
      #2;
      reset = 1'b1;
      step();
      rsp_valid = 1'b1; rsp_src_idx = 2'd2; rsp_pass_dirty = 1'b0; rsp_has_data = 1'b0;
      step();
      rsp_valid = 1'b0;
      chk("idle_rsp_err", 64'(err), 64'd1);
      chk("idle_rsp_ready", 64'(req_ready), 64'd1);
      run_vec(2, 1'b1);

      // Reset during WAIT with one snoop outstanding
      a = 48'h0000_7777_0000;
      push_txn(4'b0001, 2'd1, 1'b0, a, 12'h3C3, 1'b0, 1'b0, 4'b0011);
      accept(4'b0001, 2'd1, 1'b0, a, 12'h3C3);
      snp_ready = 1'b1;
      step();
      snp_ready = 1'b0;
      step();
      chk("wait_state_valid", 64'(snp_valid | done_valid | req_ready), 64'd0);
      reset = 1'b0;
      #1;
      done_q.delete();
      chk("abort_req_ready", 64'(req_ready), 64'd1);
      chk("abort_snp_valid", 64'(snp_valid), 64'd0);
      chk("abort_done_valid", 64'(done_valid), 64'd0);
      chk("abort_done_txnid", 64'(done_txnid), 64'd0);
      chk("abort_err", 64'(err), 64'd0);
      #2;
      reset = 1'b1;
      step();
      rsp_valid = 1'b1; rsp_src_idx = 2'd0; rsp_pass_dirty = 1'b1; rsp_has_data = 1'b1;
      done_ready = 1'b1;
      step();
      rsp_valid = 1'b0;
      step();
      chk("late_rsp_err", 64'(err), 64'd1);
      chk("late_rsp_no_done", 64'(done_valid), 64'd0);
      done_ready = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
